route_lookup_scheduler: RTL and testbench

Shares a single routing-table lookup engine among the input ports of a router. Each input port presents its head flit; the block arbitrates round-robin, decodes the destination field, reads the node's routing table and holds the resulting output-port request for that input until the packet's tail releases it. The table is runtime-writable through a configuration port, so routes no longer come from per-node memory files at elaboration.

---
 rtl/route_lookup_scheduler_if.sv | 34 +++
 rtl/route_lookup_scheduler.sv | 168 ++++++++++++++++
 tb/tb_route_lookup_scheduler.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/route_lookup_scheduler_if.sv
// Handshake and configuration bundle between input ports and the shared route-lookup engine.
// master = requester/configuration side, slave = the scheduler.
interface route_lookup_scheduler_if #(
   parameter int N             = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int PhitPerFlit   = 2,
   parameter int REQUEST_WIDTH = 2,
   parameter int PORTS         = 5
);
   localparam int FLIT_WIDTH = PhitPerFlit * DATA_WIDTH;
   localparam int DW         = (N > 1) ? $clog2(N) : 1;

   logic [PORTS-1:0]               req_valid;
   logic [PORTS*FLIT_WIDTH-1:0]    req_flit;
   logic [PORTS-1:0]               req_ready;
   logic [PORTS-1:0]               route_valid;
   logic [PORTS*REQUEST_WIDTH-1:0] route_data;
   logic [PORTS-1:0]               route_err;
   logic [PORTS-1:0]               route_release;
   logic                           cfg_we;
   logic [DW-1:0]                  cfg_addr;
   logic [REQUEST_WIDTH-1:0]       cfg_data;
   logic                           cfg_busy;

   modport master (
      output req_valid, req_flit, route_release, cfg_we, cfg_addr, cfg_data,
      input  req_ready, route_valid, route_data, route_err, cfg_busy
   );

   modport slave (
      input  req_valid, req_flit, route_release, cfg_we, cfg_addr, cfg_data,
      output req_ready, route_valid, route_data, route_err, cfg_busy
   );
endinterface

// File: rtl/route_lookup_scheduler.sv
// Round-robin shared routing-table lookup: one head flit per two cycles, route held per port
// until released; table is runtime-writable and configuration wins over lookups in IDLE.
module route_lookup_scheduler #(
   parameter int N             = 4,
   parameter int DATA_WIDTH    = 8,
   parameter int PhitPerFlit   = 2,
   parameter int REQUEST_WIDTH = 2,
   parameter int PORTS         = 5
) (
   input logic                     clk_i,
   input logic                     rst_ni,
   route_lookup_scheduler_if.slave bus
);
   localparam int FLIT_WIDTH = PhitPerFlit * DATA_WIDTH;
   localparam int DW         = (N > 1) ? $clog2(N) : 1;
   localparam int PW         = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int RW         = REQUEST_WIDTH;

   localparam logic [0:0] ST_IDLE   = 1'b0;
   localparam logic [0:0] ST_LOOKUP = 1'b1;

   localparam logic [DW:0] N_L     = (DW + 1)'(N);
   localparam logic [PW:0] PORTS_L = (PW + 1)'(PORTS);

   logic [0:0]           state_q, state_d;
   logic [PW-1:0]        rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]        grant_q, grant_d;
   logic [DW-1:0]        dest_q, dest_d;
   logic [PORTS-1:0]     req_ready_q, req_ready_d;
   logic [RW-1:0]        table_q [N];

   logic [PORTS-1:0]     eligible;
   logic [PW-1:0]        cand_idx [PORTS];
   logic                 any_eligible;
   logic [PW-1:0]        pick;
   logic                 tbl_we;
   logic                 complete;
   logic [RW-1:0]        lookup_data;
   logic                 lookup_err;

   logic [PORTS-1:0]     route_valid_vec;
   logic [PORTS-1:0]     route_err_vec;
   logic [PORTS*RW-1:0]  route_data_vec;

   // Candidate k is the k-th port at or after the round-robin pointer, wrapping.
   for (genvar gi = 0; gi < PORTS; gi++) begin : g_cand
      logic [PW:0] sum;
      assign sum          = {1'b0, rr_ptr_q} + (PW + 1)'(gi);
      assign cand_idx[gi] = (sum >= PORTS_L) ? PW'(sum - PORTS_L) : PW'(sum);
   end

   always_comb begin
      any_eligible = 1'b0;
      pick         = rr_ptr_q;
      for (int k = PORTS - 1; k >= 0; k--) begin
         if (eligible[cand_idx[k]]) begin
            any_eligible = 1'b1;
            pick         = cand_idx[k];
         end
      end
   end

   // Out-of-range destinations match no entry and fall through to the error route.
   always_comb begin
      lookup_data = '0;
      lookup_err  = 1'b1;
      for (int e = 0; e < N; e++) begin
         if (dest_q == DW'(e)) begin
            lookup_data = table_q[e];
            lookup_err  = 1'b0;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      grant_d     = grant_q;
      dest_d      = dest_q;
      tbl_we      = 1'b0;
      complete    = 1'b0;
      req_ready_d = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.cfg_we) begin
               tbl_we = ({1'b0, bus.cfg_addr} < N_L);
            end else if (any_eligible) begin
               grant_d = pick;
               dest_d  = bus.req_flit[int'(pick)*FLIT_WIDTH +: DW];
               state_d = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            complete    = 1'b1;
            req_ready_d = PORTS'(1) << grant_q;
            rr_ptr_d    = (grant_q == PW'(PORTS - 1)) ? '0 : grant_q + 1'b1;
            state_d     = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= ST_IDLE;
         rr_ptr_q    <= '0;
         grant_q     <= '0;
         dest_q      <= '0;
         req_ready_q <= '0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         grant_q     <= grant_d;
         dest_q      <= dest_d;
         req_ready_q <= req_ready_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int e = 0; e < N; e++) begin
            table_q[e] <= '0;
         end
      end else if (tbl_we) begin
         for (int e = 0; e < N; e++) begin
            if (bus.cfg_addr == DW'(e)) begin
               table_q[e] <= bus.cfg_data;
            end
         end
      end
   end

   // Per-port held route; a port is ineligible while it holds one, so set and release never collide.
   for (genvar gi = 0; gi < PORTS; gi++) begin : g_port
      logic          valid_q;
      logic          err_q;
      logic [RW-1:0] data_q;
      logic          set;

      assign set = complete && (grant_q == PW'(gi));

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            data_q  <= '0;
         end else if (set) begin
            valid_q <= 1'b1;
            err_q   <= lookup_err;
            data_q  <= lookup_data;
         end else if (bus.route_release[gi]) begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
         end
      end

      assign eligible[gi]                 = bus.req_valid[gi] && !valid_q;
      assign route_valid_vec[gi]          = valid_q;
      assign route_err_vec[gi]            = err_q;
      assign route_data_vec[gi*RW +: RW]  = data_q;
   end

   assign bus.req_ready   = req_ready_q;
   assign bus.route_valid = route_valid_vec;
   assign bus.route_err   = route_err_vec;
   assign bus.route_data  = route_data_vec;
   assign bus.cfg_busy    = (state_q == ST_LOOKUP);
endmodule

// File: tb/tb_route_lookup_scheduler.sv
// Directed bench: a spec-level model of the N=4 instance is compared every cycle, with
// hand-computed literal checks on both an N=4 and an N=3 instance.
module tb_route_lookup_scheduler;
   localparam int P  = 5;
   localparam int FW = 16;
   localparam int NA = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   route_lookup_scheduler_if #(.N(4)) ifa ();
   route_lookup_scheduler_if #(.N(3)) ifb ();

   route_lookup_scheduler #(.N(4)) dut_a (.clk_i(clk), .rst_ni(rst_n), .bus(ifa));
   route_lookup_scheduler #(.N(3)) dut_b (.clk_i(clk), .rst_ni(rst_n), .bus(ifb));

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model of instance A ----------------
   int       m_tbl [NA];
   int       m_data [P];
   bit [P-1:0] m_valid, m_err, m_ready, m_elig, m_rel;
   bit       m_busy;
   int       m_ptr, m_g, m_dest, mc;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NA; i++) m_tbl[i] = 0;
         for (int i = 0; i < P; i++) m_data[i] = 0;
         m_valid = '0; m_err = '0; m_ready = '0;
         m_busy = 1'b0; m_ptr = 0; m_g = 0; m_dest = 0;
      end else begin
         m_elig  = ifa.req_valid & ~m_valid;
         m_rel   = ifa.route_release;
         m_ready = '0;
         if (m_busy) begin
            m_data[m_g]  = (m_dest < NA) ? m_tbl[m_dest] : 0;
            m_err[m_g]   = !(m_dest < NA);
            m_valid[m_g] = 1'b1;
            m_ready[m_g] = 1'b1;
            m_ptr        = (m_g + 1) % P;
            m_busy       = 1'b0;
         end else if (ifa.cfg_we) begin
            if (int'(ifa.cfg_addr) < NA) m_tbl[ifa.cfg_addr] = int'(ifa.cfg_data);
         end else begin
            for (int k = 0; k < P; k++) begin
               mc = (m_ptr + k) % P;
               if (m_elig[mc] && !m_busy) begin
                  m_busy = 1'b1;
                  m_g    = mc;
                  m_dest = int'(ifa.req_flit[mc*FW +: FW]) % 4;
               end
            end
         end
         for (int p = 0; p < P; p++) begin
            if (m_rel[p] && !m_ready[p]) begin
               m_valid[p] = 1'b0;
               m_err[p]   = 1'b0;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         chk("model_req_ready", ifa.req_ready, m_ready);
         chk("model_route_valid", ifa.route_valid, m_valid);
         chk("model_route_err", ifa.route_err, m_err);
         chk("model_cfg_busy", ifa.cfg_busy, m_busy);
         for (int p = 0; p < P; p++) begin
            if (m_valid[p])
               chk($sformatf("model_route_data%0d", p), ifa.route_data[p*2 +: 2], m_data[p]);
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   function automatic logic [1:0] rda(input int p);
      return ifa.route_data[p*2 +: 2];
   endfunction

   function automatic logic [1:0] rdb(input int p);
      return ifb.route_data[p*2 +: 2];
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      ifa.req_valid = '0; ifa.req_flit = '0; ifa.route_release = '0;
      ifa.cfg_we = 1'b0; ifa.cfg_addr = '0; ifa.cfg_data = '0;
      ifb.req_valid = '0; ifb.req_flit = '0; ifb.route_release = '0;
      ifb.cfg_we = 1'b0; ifb.cfg_addr = '0; ifb.cfg_data = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_route_valid", ifa.route_valid, 0);
      chk("rst_req_ready", ifa.req_ready, 0);
      chk("rst_route_data", ifa.route_data, 0);
      chk("rst_route_err", ifa.route_err, 0);
      chk("rst_cfg_busy", ifa.cfg_busy, 0);
      rst_n = 1'b1;
      chk_en = 1'b1;
   endtask

   task automatic program_a();
      for (int a = 0; a < 4; a++) begin
         ifa.cfg_we = 1'b1; ifa.cfg_addr = 2'(a); ifa.cfg_data = 2'(a);
         tick();
      end
      ifa.cfg_we = 1'b0;
   endtask

   task automatic set_flit_a(input int p, input logic [15:0] f);
      ifa.req_flit[p*FW +: FW] = f;
   endtask

   int got_port [3];
   int got_tick [3];
   int nserved;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      // ---- test 1: single lookup, upper flit bits ignored ----
      do_reset();
      program_a();
      ifa.req_valid[2] = 1'b1; set_flit_a(2, 16'h5A07);
      tick();
      chk("t1_busy_after_grant", ifa.cfg_busy, 1);
      chk("t1_no_early_ready", ifa.req_ready, 0);
      tick();
      chk("t1_ready_pulse", ifa.req_ready, 5'b00100);
      chk("t1_route_valid", ifa.route_valid[2], 1);
      chk("t1_route_data", rda(2), 3);
      ifa.req_valid[2] = 1'b0;
      tick();
      chk("t1_ready_single", ifa.req_ready, 0);
      chk("t1_valid_held", ifa.route_valid[2], 1);
      ifa.route_release[2] = 1'b1;
      tick();
      ifa.route_release[2] = 1'b0;
      chk("t1_released", ifa.route_valid[2], 0);

      // ---- test 2: ports 0,1,4 together from rr_ptr 0 ----
      do_reset();
      program_a();
      set_flit_a(0, 16'h0001); set_flit_a(1, 16'h0002); set_flit_a(4, 16'h0000);
      ifa.req_valid = 5'b10011;
      nserved = 0;
      for (int i = 0; i < 3; i++) begin got_port[i] = -1; got_tick[i] = -1; end
      for (int t = 1; t <= 12 && nserved < 3; t++) begin
         tick();
         for (int p = 0; p < P; p++) begin
            if (ifa.req_ready[p]) begin
               got_port[nserved] = p;
               got_tick[nserved] = t;
               nserved++;
               ifa.req_valid[p] = 1'b0;
            end
         end
      end
      chk("t2_order0", got_port[0], 0); chk("t2_tick0", got_tick[0], 2);
      chk("t2_order1", got_port[1], 1); chk("t2_tick1", got_tick[1], 4);
      chk("t2_order2", got_port[2], 4); chk("t2_tick2", got_tick[2], 6);
      chk("t2_all_held", ifa.route_valid, 5'b10011);
      chk("t2_data0", rda(0), 1); chk("t2_data1", rda(1), 2); chk("t2_data4", rda(4), 0);
      ifa.route_release = 5'b10011;
      tick();
      ifa.route_release = '0;
      // pointer wrapped to 0: port 0 beats port 3
      set_flit_a(0, 16'h0001); set_flit_a(3, 16'h0003);
      ifa.req_valid = 5'b01001;
      tick(); tick();
      chk("t2_ptr_wrap_first", ifa.req_ready, 5'b00001);
      ifa.req_valid[0] = 1'b0;
      tick(); tick();
      chk("t2_ptr_wrap_second", ifa.req_ready, 5'b01000);
      chk("t2_data3", rda(3), 3);
      ifa.req_valid[3] = 1'b0;
      ifa.route_release = 5'b01001;
      tick();
      ifa.route_release = '0;

      // ---- test 3: cfg write collides with request; cfg during LOOKUP ignored ----
      ifa.req_valid[1] = 1'b1; set_flit_a(1, 16'h0002);
      ifa.cfg_we = 1'b1; ifa.cfg_addr = 2'd2; ifa.cfg_data = 2'd1;
      tick();
      ifa.cfg_we = 1'b0;
      chk("t3_write_first", ifa.cfg_busy, 0);
      tick();
      chk("t3_grant_late", ifa.cfg_busy, 1);
      tick();
      chk("t3_ready", ifa.req_ready, 5'b00010);
      chk("t3_new_value", rda(1), 1);
      ifa.req_valid[1] = 1'b0;
      ifa.req_valid[3] = 1'b1; set_flit_a(3, 16'h0001);
      tick();
      chk("t3_busy2", ifa.cfg_busy, 1);
      ifa.cfg_we = 1'b1; ifa.cfg_addr = 2'd1; ifa.cfg_data = 2'd3;
      tick();
      ifa.cfg_we = 1'b0;
      ifa.req_valid[3] = 1'b0;
      chk("t3_ready3", ifa.req_ready, 5'b01000);
      chk("t3_data3", rda(3), 1);
      ifa.route_release = 5'b01010;
      tick();
      ifa.route_release = '0;
      ifa.req_valid[3] = 1'b1;
      tick(); tick();
      chk("t3_entry_unchanged", rda(3), 1);
      ifa.req_valid[3] = 1'b0;
      ifa.route_release[3] = 1'b1;
      tick();
      ifa.route_release[3] = 1'b0;

      // ---- test 4: held route survives table write; release with req_valid high ----
      ifa.req_valid[0] = 1'b1; set_flit_a(0, 16'h0000);
      tick(); tick();
      chk("t4_first_data", rda(0), 0);
      ifa.cfg_we = 1'b1; ifa.cfg_addr = 2'd0; ifa.cfg_data = 2'd2;
      tick();
      ifa.cfg_we = 1'b0;
      chk("t4_held_unchanged", rda(0), 0);
      chk("t4_held_valid", ifa.route_valid[0], 1);
      ifa.route_release[0] = 1'b1;
      tick();
      ifa.route_release[0] = 1'b0;
      chk("t4_dropped", ifa.route_valid[0], 0);
      tick();
      chk("t4_relookup_busy", ifa.cfg_busy, 1);
      tick();
      chk("t4_relookup_ready", ifa.req_ready, 5'b00001);
      chk("t4_relookup_data", rda(0), 2);
      ifa.req_valid[0] = 1'b0;
      ifa.route_release[0] = 1'b1;
      tick();
      ifa.route_release[0] = 1'b0;

      // ---- test 5: reset during LOOKUP ----
      set_flit_a(0, 16'h0001); set_flit_a(2, 16'h0003);
      ifa.req_valid = 5'b00101;
      tick();
      chk("t5_in_lookup", ifa.cfg_busy, 1);
      rst_n = 1'b0;
      #1;
      chk("t5_rst_busy", ifa.cfg_busy, 0);
      chk("t5_rst_valid", ifa.route_valid, 0);
      chk("t5_rst_ready", ifa.req_ready, 0);
      @(posedge clk);
      #1;
      chk("t5_no_ready_in_rst", ifa.req_ready, 0);
      rst_n = 1'b1;
      tick(); tick();
      chk("t5_restart_port0", ifa.req_ready, 5'b00001);
      chk("t5_table_cleared0", rda(0), 0);
      ifa.req_valid[0] = 1'b0;
      tick(); tick();
      chk("t5_then_port2", ifa.req_ready, 5'b00100);
      chk("t5_table_cleared2", rda(2), 0);
      ifa.req_valid[2] = 1'b0;
      ifa.route_release = 5'b00101;
      tick();
      ifa.route_release = '0;

      // ---- test 6: N=3 instance, out-of-range destination ----
      for (int a = 0; a < 3; a++) begin
         ifb.cfg_we = 1'b1; ifb.cfg_addr = 2'(a); ifb.cfg_data = 2'd3;
         tick();
      end
      ifb.cfg_we = 1'b0;
      ifb.req_valid[1] = 1'b1; ifb.req_flit[1*FW +: FW] = 16'hABC3;
      tick(); tick();
      chk("t6_ready", ifb.req_ready, 5'b00010);
      chk("t6_err", ifb.route_err[1], 1);
      chk("t6_data_zero", rdb(1), 0);
      chk("t6_valid", ifb.route_valid[1], 1);
      ifb.req_valid[1] = 1'b0;
      ifb.req_valid[0] = 1'b1; ifb.req_flit[0*FW +: FW] = 16'h0002;
      tick(); tick();
      chk("t6_inrange_data", rdb(0), 3);
      chk("t6_inrange_err", ifb.route_err[0], 0);
      ifb.req_valid[0] = 1'b0;
      ifb.route_release[1] = 1'b1;
      tick();
      ifb.route_release[1] = 1'b0;
      chk("t6_rel_valid", ifb.route_valid[1], 0);
      chk("t6_rel_err", ifb.route_err[1], 0);
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
